// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding and default widths.
package mem_arbiter_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = (req == 2'b11) ? ~last : req[1];
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM; one access per 3 cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ready0,
  output logic          ready1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          owner
);
  state_t state, next_state;
  logic   gnt_valid, gnt_idx;
  logic   last_grant;
  logic   lat_we;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_arb2 u_rr (
    .req       ({req1, req0}),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    sel_we    = gnt_idx ? we1    : we0;
    sel_addr  = gnt_idx ? addr1  : addr0;
    sel_wdata = gnt_idx ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (gnt_valid) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ram_addr/ram_din double as the latched request address/data, so they are
  // already stable on the RAM pins for the whole ACCESS cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready0     <= 1'b0;
      ready1     <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_we     <= 1'b0;
      busy       <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
    end else begin
      ready0 <= 1'b0;
      ready1 <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner    <= gnt_idx;
            lat_we   <= sel_we;
            ram_addr <= sel_addr;
            ram_din  <= sel_wdata;
            ram_we   <= sel_we;
            busy     <= 1'b1;
          end
        end
        ACCESS: ram_we <= 1'b0;
        RESP: begin
          // ram_dout is valid this cycle, so the capture lands with the ready pulse
          busy       <= 1'b0;
          last_grant <= owner;
          if (owner) begin
            ready1 <= 1'b1;
            if (!lat_we) rdata1 <= ram_dout;
          end else begin
            ready0 <= 1'b1;
            if (!lat_we) rdata0 <= ram_dout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ready0, ready1, ram_we, busy, owner;
  logic [DW-1:0] rdata0, rdata1, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ready0(ready0), .ready1(ready1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          p;
    logic [DW-1:0] d;
    int            c;
  } rsp_t;

  rsp_t          exp_q[$];
  rsp_t          obs_q[$];
  logic [DW-1:0] mem[1024];
  logic [DW-1:0] ref_mem[1024];
  logic [DW-1:0] exp_rd[2];
  int            cyc = 0;
  int            nwr = 0;
  logic [AW-1:0] last_wa;
  logic [DW-1:0] last_wd;
  int            checks = 0;
  int            errors = 0;

  // behavioural RAM: read data one cycle after the address
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      nwr     <= nwr + 1;
      last_wa <= ram_addr;
      last_wd <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ready0) obs_q.push_back('{p: 1'b0, d: rdata0, c: cyc});
      if (ready1) obs_q.push_back('{p: 1'b1, d: rdata1, c: cyc});
    end
  end

  task automatic issue(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rsp_t e;
    e.p = p;
    e.c = 0;
    if (w) begin
      ref_mem[a] = d;
      e.d = exp_rd[p];
    end else begin
      e.d = ref_mem[a];
      exp_rd[p] = ref_mem[a];
    end
    exp_q.push_back(e);
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic wait_rdy(input bit p, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (p ? ready1 : ready0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready0, ready1, ram_we, busy, owner} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 00000", {ready0, ready1, ram_we, busy, owner});
    end
    checks++;
    if (rdata0 !== '0 || rdata1 !== '0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h, expected 0/0", rdata0, rdata1);
    end
    checks++;
    if (ram_addr !== '0 || ram_din !== '0) begin
      errors++;
      $display("FAIL reset_ram: got addr %h din %h, expected 0/0", ram_addr, ram_din);
    end
    rst = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic test_write_read();
    int n, w0;
    rsp_t e, o;
    w0 = nwr;
    issue(0, 1, 10'h005, 32'hDEADBEEF);
    wait_rdy(0, 8, n);
    req0 = 1'b0;
    checks++;
    if (n !== 3) begin errors++; $display("FAIL wr_latency: got %0d, expected 3", n); end
    checks++;
    if (nwr - w0 !== 1 || last_wa !== 10'h005 || last_wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_ram: got %0d writes addr %h data %h, expected 1 005 deadbeef", nwr - w0, last_wa, last_wd);
    end
    issue(0, 0, 10'h005, '0);
    wait_rdy(0, 8, n);
    req0 = 1'b0;
    checks++;
    if (n !== 3) begin errors++; $display("FAIL rd_latency: got %0d, expected 3", n); end
    checks++;
    if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h, expected deadbeef", rdata0); end
    checks++;
    if (nwr - w0 !== 1) begin errors++; $display("FAIL rd_nowrite: got %0d writes, expected 1", nwr - w0); end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL wr_rd_resp: got none, expected port %0d", e.p); end
      else begin
        o = obs_q.pop_front();
        if (o.p !== e.p || o.d !== e.d) begin
          errors++;
          $display("FAIL wr_rd_resp: got port %0d data %h, expected port %0d data %h", o.p, o.d, e.p, e.d);
        end
      end
    end
  endtask

  task automatic test_tie();
    int n0, n1;
    rsp_t e, o;
    do_reset();
    issue(0, 0, 10'h005, '0);
    issue(1, 0, 10'h005, '0);
    wait_rdy(0, 8, n0);
    req0 = 1'b0;
    wait_rdy(1, 8, n1);
    req1 = 1'b0;
    checks++;
    if (n0 !== 3 || n1 !== 3) begin
      errors++;
      $display("FAIL tie_timing: got %0d then %0d, expected 3 then 3", n0, n1);
    end
    // single-cycle pulses: exactly two observations in order 0,1
    #1;
    checks++;
    if (obs_q.size() !== 2) begin errors++; $display("FAIL tie_pulses: got %0d, expected 2", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL tie_order: got none, expected port %0d", e.p); end
      else begin
        o = obs_q.pop_front();
        if (o.p !== e.p || o.d !== e.d) begin
          errors++;
          $display("FAIL tie_order: got port %0d data %h, expected port %0d data %h", o.p, o.d, e.p, e.d);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_late_req();
    int n0, n1;
    rsp_t e, o;
    issue(0, 1, 10'h030, 32'h0C0C_0030);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || owner !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 10'h030) begin
      errors++;
      $display("FAIL late_access: got busy %b owner %b we %b addr %h, expected 1 0 1 030", busy, owner, ram_we, ram_addr);
    end
    issue(1, 0, 10'h030, '0);
    wait_rdy(0, 8, n0);
    req0 = 1'b0;
    wait_rdy(1, 8, n1);
    req1 = 1'b0;
    checks++;
    if (n0 !== 2 || n1 !== 3) begin
      errors++;
      $display("FAIL late_timing: got %0d then %0d, expected 2 then 3", n0, n1);
    end
    checks++;
    if (rdata1 !== 32'h0C0C_0030) begin errors++; $display("FAIL late_data: got %h, expected 0c0c0030", rdata1); end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL late_resp: got none, expected port %0d", e.p); end
      else begin
        o = obs_q.pop_front();
        if (o.p !== e.p || o.d !== e.d) begin
          errors++;
          $display("FAIL late_resp: got port %0d data %h, expected port %0d data %h", o.p, o.d, e.p, e.d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit            w0[3] = '{1'b1, 1'b0, 1'b1};
    logic [AW-1:0] a0[3] = '{10'h010, 10'h010, 10'h011};
    bit            w1[3] = '{1'b1, 1'b0, 1'b0};
    logic [AW-1:0] a1[3] = '{10'h020, 10'h020, 10'h005};
    int            n0 = 1, n1 = 1, got = 0, prev = -1;
    rsp_t          e, o;
    issue(0, w0[0], a0[0], 32'hA0A0_0000);
    issue(1, w1[0], a1[0], 32'hB0B0_0000);
    for (int i = 1; i <= 40 && got < 6; i++) begin
      @(negedge clk);
      if (ready0 || ready1) begin
        got++;
        if (prev >= 0) begin
          checks++;
          if (i - prev !== 3) begin errors++; $display("FAIL b2b_gap: got %0d, expected 3", i - prev); end
        end
        prev = i;
      end
      if (ready0) begin
        if (n0 < 3) begin issue(0, w0[n0], a0[n0], 32'hA0A0_0000 + n0); n0++; end
        else req0 = 1'b0;
      end
      if (ready1) begin
        if (n1 < 3) begin issue(1, w1[n1], a1[n1], 32'hB0B0_0000 + n1); n1++; end
        else req1 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checks++;
    if (got !== 6) begin errors++; $display("FAIL b2b_count: got %0d, expected 6", got); end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_resp: got none, expected port %0d", e.p); end
      else begin
        o = obs_q.pop_front();
        if (o.p !== e.p || o.d !== e.d) begin
          errors++;
          $display("FAIL b2b_resp: got port %0d data %h, expected port %0d data %h", o.p, o.d, e.p, e.d);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, w0;
    rsp_t e, o;
    issue(0, 1, 10'h3FF, 32'h1111_1111);
    wait_rdy(0, 8, n);
    req0 = 1'b0;
    #1;
    exp_q.delete();
    obs_q.delete();
    w0 = nwr;
    // interrupted write: driven directly so neither model nor scoreboard expects it
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h3FF; wdata0 = 32'hBAD0_BAD0;
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    checks++;
    if ({ready0, ready1, ram_we, busy, owner} !== 5'b0 || rdata0 !== '0 || rdata1 !== '0 ||
        ram_addr !== '0 || ram_din !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got ctrl %b rdata %h/%h addr %h din %h, expected all 0",
               {ready0, ready1, ram_we, busy, owner}, rdata0, rdata1, ram_addr, ram_din);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() !== 0 || nwr - w0 !== 0) begin
      errors++;
      $display("FAIL midrst_quiet: got %0d readies %0d writes, expected 0 0", obs_q.size(), nwr - w0);
    end
    issue(0, 0, 10'h3FF, '0);
    wait_rdy(0, 8, n);
    req0 = 1'b0;
    checks++;
    if (n !== 3) begin errors++; $display("FAIL midrst_latency: got %0d, expected 3", n); end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL midrst_resp: got none, expected port %0d", e.p); end
      else begin
        o = obs_q.pop_front();
        if (o.p !== e.p || o.d !== e.d) begin
          errors++;
          $display("FAIL midrst_resp: got port %0d data %h, expected port %0d data %h", o.p, o.d, e.p, e.d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_late_req();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL stray_ready: got %0d, expected 0", obs_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
